// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared definitions for the byte-wide RAM arbiter.
//   mem_state_t  - arbiter FSM encoding (MEM_IDLE/MEM_FETCH/MEM_LOAD/MEM_STORE)
//   LEN_B/H/W    - access length codes (bytes minus one)
//   IO_REGION    - value of addr[17:16] that selects the UART/IO window
//   is_io()      - true when a byte address falls in the IO window
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'd0,
    MEM_FETCH = 2'd1,
    MEM_LOAD  = 2'd2,
    MEM_STORE = 2'd3
  } mem_state_t;

  localparam logic [3:0] LEN_B = 4'd0;
  localparam logic [3:0] LEN_H = 4'd1;
  localparam logic [3:0] LEN_W = 4'd3;

  localparam logic [1:0] IO_REGION = 2'b11;

  function automatic logic is_io(input logic [31:0] addr);
    return addr[17:16] == IO_REGION;
  endfunction

endpackage

// File: rtl/mem_arbiter_ld_ext.sv
// mem_ld_ext: combinational sign/zero extension of an assembled load word.
//   word - little-endian assembled bytes (unused upper bytes don't matter)
//   len  - bytes minus one (LEN_B, LEN_H, LEN_W)
//   sext - replicate the top bit of the loaded field when set
//   ext  - extended 32-bit result
module mem_ld_ext
  import mem_arbiter_pkg::*;
(
  input  logic [31:0] word,
  input  logic [3:0]  len,
  input  logic        sext,
  output logic [31:0] ext
);

  always_comb begin
    ext = word;
    case (len)
      LEN_B:   ext = {{24{sext & word[7]}},  word[7:0]};
      LEN_H:   ext = {{16{sext & word[15]}}, word[15:0]};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port byte-wide RAM controller. Serialises fetch, load
// and store requests onto an 8-bit synchronous RAM bus, one byte per cycle,
// and returns assembled/extended words with one-cycle done pulses.
//
// Ports:
//   clk, rst (sync, active-high), rdy (low freezes everything), rob_rb
//   if_ena/if_addr        -> if_done/if_data           (4-byte fetch)
//   ld_ena/addr/len/sext/src -> ld_done/ld_data/ld_done_src
//   st_ena/addr/len/data  -> st_done
//   mem_din (byte valid the cycle after its address), mem_dout, mem_a, mem_wr
//   io_buffer_full        UART back-pressure
//
// Build option: define MEMARB_IO_STALL_EN to hold off stores into the IO
// window (addr[17:16]==2'b11) while io_buffer_full is high.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int ROB_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              rob_rb,
  input  logic              if_ena,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              ld_ena,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [3:0]        ld_len,
  input  logic              ld_sext,
  input  logic [ROB_W-1:0]  ld_src,
  output logic              ld_done,
  output logic [31:0]       ld_data,
  output logic [ROB_W-1:0]  ld_done_src,
  input  logic              st_ena,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [3:0]        st_len,
  input  logic [31:0]       st_data,
  output logic              st_done,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  mem_state_t        state, state_n;
  logic [ADDR_W-1:0] base;      // latched start address
  logic [3:0]        len_q;     // latched length code
  logic [2:0]        last;      // index of final byte
  logic [2:0]        cnt;       // bytes captured (reads) / byte on bus (stores)
  logic [2:0]        icnt;      // read byte currently presented on mem_a
  logic [2:0]        cnt_n, icnt_n;
  logic              rd_vld;    // mem_din carries a requested byte this cycle
  logic              sext_q;
  logic [ROB_W-1:0]  tag_q;
  logic [31:0]       wdata;
  logic [31:0]       rbuf;
  logic              wr_q;
  logic              rdy_prev;
  logic [7:0]        din_hold;
  logic [7:0]        din_eff;
  logic [31:0]       asm_word;
  logic [31:0]       ext_word;
  logic              any_done;
  logic              st_block;
  logic              acc_st, acc_ld, acc_if;
  logic              rd_fin, st_fin;

  assign last     = len_q[2:0];
  assign cnt_n    = cnt + 3'd1;
  assign icnt_n   = icnt + 3'd1;
  assign any_done = if_done | ld_done | st_done;

  // Writes are suppressed while frozen; the byte is re-driven on resume.
  assign mem_wr = wr_q & rdy;

`ifdef MEMARB_IO_STALL_EN
  assign st_block = io_buffer_full & is_io(32'(st_addr));
`else
  logic unused_io;
  assign unused_io = io_buffer_full;
  assign st_block  = 1'b0;
`endif

  // The RAM keeps returning mem_a's byte while we are frozen, so the byte
  // that was valid when rdy dropped would be overwritten by the next
  // address's data. Hold it across the freeze and use it on resume.
  assign din_eff = rdy_prev ? mem_din : din_hold;

  // Read buffer with the byte arriving this cycle merged in, so the final
  // byte can be returned in the same edge it is captured.
  always_comb begin
    asm_word = rbuf;
    asm_word[{cnt[1:0], 3'b000} +: 8] = din_eff;
  end

  mem_ld_ext u_ext (
    .word (asm_word),
    .len  (len_q),
    .sext (sext_q),
    .ext  (ext_word)
  );

  // Next-state and transaction strobes.
  always_comb begin
    state_n = state;
    acc_st  = 1'b0;
    acc_ld  = 1'b0;
    acc_if  = 1'b0;
    rd_fin  = 1'b0;
    st_fin  = 1'b0;
    case (state)
      MEM_IDLE: begin
        // A done pulse still high means its requester's ena may not have
        // dropped yet; skip this cycle so it is not re-granted.
        if (!any_done) begin
          if (st_ena && !st_block) begin
            acc_st  = 1'b1;
            state_n = MEM_STORE;
          end else if (ld_ena && !rob_rb) begin
            acc_ld  = 1'b1;
            state_n = MEM_LOAD;
          end else if (if_ena && !rob_rb) begin
            acc_if  = 1'b1;
            state_n = MEM_FETCH;
          end
        end
      end
      MEM_FETCH, MEM_LOAD: begin
        if (rob_rb) begin
          state_n = MEM_IDLE;
        end else if (rd_vld && cnt == last) begin
          rd_fin  = 1'b1;
          state_n = MEM_IDLE;
        end
      end
      MEM_STORE: begin
        // Stores are already committed, so rollback does not stop them.
        if (cnt == last) begin
          st_fin  = 1'b1;
          state_n = MEM_IDLE;
        end
      end
      default: state_n = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)      state <= MEM_IDLE;
    else if (rdy) state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base        <= '0;
      len_q       <= LEN_B;
      cnt         <= '0;
      icnt        <= '0;
      rd_vld      <= 1'b0;
      sext_q      <= 1'b0;
      tag_q       <= '0;
      wdata       <= '0;
      rbuf        <= '0;
      wr_q        <= 1'b0;
      rdy_prev    <= 1'b0;
      din_hold    <= '0;
      mem_a       <= '0;
      mem_dout    <= '0;
      if_done     <= 1'b0;
      if_data     <= '0;
      ld_done     <= 1'b0;
      ld_data     <= '0;
      ld_done_src <= '0;
      st_done     <= 1'b0;
    end else begin
      rdy_prev <= rdy;
      din_hold <= din_eff;
      if (rdy) begin
        if_done <= 1'b0;
        ld_done <= 1'b0;
        st_done <= 1'b0;
        case (state)
          MEM_IDLE: begin
            cnt    <= '0;
            icnt   <= '0;
            rd_vld <= 1'b0;
            rbuf   <= '0;
            if (acc_st) begin
              base     <= st_addr;
              len_q    <= st_len;
              wdata    <= st_data;
              mem_a    <= st_addr;
              mem_dout <= st_data[7:0];
              wr_q     <= 1'b1;
            end else if (acc_ld) begin
              base   <= ld_addr;
              len_q  <= ld_len;
              sext_q <= ld_sext;
              tag_q  <= ld_src;
              mem_a  <= ld_addr;
              wr_q   <= 1'b0;
            end else if (acc_if) begin
              base   <= if_addr;
              len_q  <= LEN_W;
              sext_q <= 1'b0;
              mem_a  <= if_addr;
              wr_q   <= 1'b0;
            end
          end
          MEM_FETCH, MEM_LOAD: begin
            if (!rob_rb) begin
              // Address runs one cycle ahead of the captured data.
              if (icnt != last) begin
                icnt  <= icnt_n;
                mem_a <= base + ADDR_W'(icnt_n);
              end
              rd_vld <= 1'b1;
              if (rd_vld) begin
                rbuf <= asm_word;
                cnt  <= cnt_n;
              end
              if (rd_fin) begin
                if (state == MEM_FETCH) begin
                  if_done <= 1'b1;
                  if_data <= asm_word;
                end else begin
                  ld_done     <= 1'b1;
                  ld_data     <= ext_word;
                  ld_done_src <= tag_q;
                end
              end
            end
          end
          MEM_STORE: begin
            if (st_fin) begin
              wr_q    <= 1'b0;
              st_done <= 1'b1;
            end else begin
              cnt      <= cnt_n;
              mem_a    <= base + ADDR_W'(cnt_n);
              mem_dout <= wdata[{cnt_n[1:0], 3'b000} +: 8];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. A synchronous RAM model
// answers the bus; expected done data/cycle and write bytes are queued when
// each request is driven and compared when the DUT produces them.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        rob_rb;
  logic        if_ena;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ld_ena;
  logic [31:0] ld_addr;
  logic [3:0]  ld_len;
  logic        ld_sext;
  logic [3:0]  ld_src;
  logic        ld_done;
  logic [31:0] ld_data;
  logic [3:0]  ld_done_src;
  logic        st_ena;
  logic [31:0] st_addr;
  logic [3:0]  st_len;
  logic [31:0] st_data;
  logic        st_done;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  mem_arbiter #(.ADDR_W(32), .ROB_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rob_rb(rob_rb),
    .if_ena(if_ena), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ld_ena(ld_ena), .ld_addr(ld_addr), .ld_len(ld_len), .ld_sext(ld_sext),
    .ld_src(ld_src), .ld_done(ld_done), .ld_data(ld_data),
    .ld_done_src(ld_done_src),
    .st_ena(st_ena), .st_addr(st_addr), .st_len(st_len), .st_data(st_data),
    .st_done(st_done),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  typedef struct {
    logic [31:0] data;
    logic [31:0] tag;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  exp_t if_q[$];
  exp_t ld_q[$];
  exp_t st_q[$];
  wr_t  wr_q[$];
  exp_t me;
  wr_t  mw;

  logic [7:0] ram [0:(1<<18)-1];
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int ld_pulses = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous read-first RAM: byte for mem_a appears the next cycle.
  always @(posedge clk) begin
    mem_din <= ram[mem_a[17:0]];
    if (mem_wr) ram[mem_a[17:0]] = mem_dout;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Scoreboard side: compare whatever the DUT produces this cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_done) begin
        if (if_q.size() == 0) chk("if_unexpected", 32'd1, 32'd0);
        else begin
          me = if_q.pop_front();
          chk("if_data", if_data, me.data);
          chk("if_cycle", 32'(cyc), 32'(me.cyc));
        end
      end
      if (ld_done) begin
        ld_pulses++;
        if (ld_q.size() == 0) chk("ld_unexpected", 32'd1, 32'd0);
        else begin
          me = ld_q.pop_front();
          chk("ld_data", ld_data, me.data);
          chk("ld_tag", 32'(ld_done_src), me.tag);
          chk("ld_cycle", 32'(cyc), 32'(me.cyc));
        end
      end
      if (st_done) begin
        if (st_q.size() == 0) chk("st_unexpected", 32'd1, 32'd0);
        else begin
          me = st_q.pop_front();
          chk("st_cycle", 32'(cyc), 32'(me.cyc));
        end
      end
      if (mem_wr) begin
        if (wr_q.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
        else begin
          mw = wr_q.pop_front();
          chk("wr_addr", mem_a, mw.addr);
          chk("wr_byte", 32'(mem_dout), 32'(mw.data));
        end
      end
    end
  end

  // acc: cycles from drive until the accepting edge; extra: frozen cycles.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int acc, input int extra);
    exp_t e;
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1;
    e.data = d; e.tag = 0; e.cyc = cyc + acc + 5 + extra;
    if_q.push_back(e);
    if_addr = a; if_ena = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (if_done) begin seen = 1'b1; break; end
    end
    if_ena = 1'b0;
    if (!seen) chk("if_timeout", 32'd0, 32'd1);
  endtask

  task automatic load(input logic [31:0] a, input logic [3:0] len, input logic sx,
                      input logic [3:0] tag, input logic [31:0] d, input int acc, input int extra);
    exp_t e;
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1;
    e.data = d; e.tag = 32'(tag); e.cyc = cyc + acc + int'(len) + 2 + extra;
    ld_q.push_back(e);
    ld_addr = a; ld_len = len; ld_sext = sx; ld_src = tag; ld_ena = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (ld_done) begin seen = 1'b1; break; end
    end
    ld_ena = 1'b0;
    if (!seen) chk("ld_timeout", 32'd0, 32'd1);
  endtask

  task automatic store(input logic [31:0] a, input logic [3:0] len, input logic [31:0] d, input int acc);
    exp_t e;
    wr_t  w;
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1;
    e.data = 0; e.tag = 0; e.cyc = cyc + acc + int'(len) + 1;
    st_q.push_back(e);
    for (int k = 0; k <= int'(len); k++) begin
      w.addr = a + 32'(k);
      w.data = d[8*k +: 8];
      wr_q.push_back(w);
    end
    st_addr = a; st_len = len; st_data = d; st_ena = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (st_done) begin seen = 1'b1; break; end
    end
    st_ena = 1'b0;
    if (!seen) chk("st_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    for (int i = 0; i < (1 << 18); i++) ram[i] = 8'h00;
    ram[18'h01000] = 8'h13; ram[18'h01001] = 8'h05;
    ram[18'h01002] = 8'h00; ram[18'h01003] = 8'h00;
    ram[18'h01010] = 8'h93; ram[18'h01011] = 8'h00;
    ram[18'h01012] = 8'h10; ram[18'h01013] = 8'h00;
    ram[18'h02000] = 8'h80;
    ram[18'h02010] = 8'h80; ram[18'h02011] = 8'hFF;
    ram[18'h02020] = 8'h11; ram[18'h02021] = 8'h22;
    ram[18'h02022] = 8'h33; ram[18'h02023] = 8'h44;
    ram[18'h02030] = 8'hDE; ram[18'h02031] = 8'hAD;
    ram[18'h02032] = 8'hBE; ram[18'h02033] = 8'hEF;

    rst = 1'b1; rdy = 1'b1; rob_rb = 1'b0; io_buffer_full = 1'b0;
    if_ena = 1'b0; if_addr = '0;
    ld_ena = 1'b0; ld_addr = '0; ld_len = '0; ld_sext = 1'b0; ld_src = '0;
    st_ena = 1'b0; st_addr = '0; st_len = '0; st_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_if_done", 32'(if_done), 32'd0);
    chk("rst_ld_done", 32'(ld_done), 32'd0);
    chk("rst_st_done", 32'(st_done), 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    chk("rst_ld_src", 32'(ld_done_src), 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_dout", 32'(mem_dout), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic reads: 5-cycle fetch, 2-cycle lb, halves with and without sext.
    fetch(32'h1000, 32'h0000_0513, 1, 0);
    load(32'h2000, 4'd0, 1'b1, 4'd5, 32'hFFFF_FF80, 1, 0);
    load(32'h2000, 4'd0, 1'b0, 4'd2, 32'h0000_0080, 1, 0);
    load(32'h2010, 4'd1, 1'b0, 4'd7, 32'h0000_FF80, 1, 0);
    load(32'h2010, 4'd1, 1'b1, 4'd9, 32'hFFFF_FF80, 1, 0);
    load(32'h2020, 4'd3, 1'b1, 4'd3, 32'h4433_2211, 1, 0);

    // Word store, then the same with a rollback in its second byte.
    store(32'h3000, 4'd3, 32'hDEAD_BEEF, 1);
    fork
      store(32'h3004, 4'd3, 32'hCAFE_F00D, 1);
      begin
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1 rob_rb = 1'b1;
        @(posedge clk); #1 rob_rb = 1'b0;
      end
    join

    // Simultaneous requests: store, then load, then fetch, bubble between.
    fork
      store(32'h3100, 4'd1, 32'h0000_1234, 1);
      load(32'h2020, 4'd3, 1'b0, 4'd1, 32'h4433_2211, 5, 0);
      fetch(32'h1010, 32'h0010_0093, 12, 0);
    join

    // Rollback in the 2nd byte of a word load: no done, arbiter free again.
    p0 = ld_pulses;
    @(posedge clk); #1;
    ld_addr = 32'h2030; ld_len = 4'd3; ld_sext = 1'b0; ld_src = 4'd4; ld_ena = 1'b1;
    repeat (2) @(posedge clk);
    #1 rob_rb = 1'b1; ld_ena = 1'b0;
    @(posedge clk); #1 rob_rb = 1'b0;
    fetch(32'h1000, 32'h0000_0513, 1, 0);
    repeat (4) @(negedge clk);
    chk("rb_no_ld_done", 32'(ld_pulses - p0), 32'd0);

    // rdy low for 3 cycles mid-load stretches latency by exactly 3.
    fork
      load(32'h2030, 4'd3, 1'b0, 4'd6, 32'hEFBE_ADDE, 1, 3);
      begin
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1 rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rdy = 1'b1;
      end
    join

    // IO-window store with the UART buffer full.
    io_buffer_full = 1'b1;
`ifdef MEMARB_IO_STALL_EN
    fork
      store(32'h0003_0000, 4'd0, 32'h0000_005A, 5);
      begin
        @(posedge clk); #1;
        repeat (4) @(posedge clk);
        #1 io_buffer_full = 1'b0;
      end
    join
`else
    store(32'h0003_0000, 4'd0, 32'h0000_005A, 1);
`endif
    io_buffer_full = 1'b0;

    repeat (5) @(negedge clk);
    chk("if_q_left", 32'(if_q.size()), 32'd0);
    chk("ld_q_left", 32'(ld_q.size()), 32'd0);
    chk("st_q_left", 32'(st_q.size()), 32'd0);
    chk("wr_q_left", 32'(wr_q.size()), 32'd0);
    chk("ram_3000", {ram[18'h03003], ram[18'h03002], ram[18'h03001], ram[18'h03000]}, 32'hDEAD_BEEF);
    chk("ram_3004", {ram[18'h03007], ram[18'h03006], ram[18'h03005], ram[18'h03004]}, 32'hCAFE_F00D);
    chk("ram_30000", 32'(ram[18'h30000]), 32'h0000_005A);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
